// File: rtl/pwm_car_pkg.sv
// Shared definitions for the motor PWM path: ramp FSM state encoding,
// H-bridge direction constants and the default datapath width.
package pwm_car_pkg;

  localparam int W_DEF = 32;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    DECEL = 2'd2,
    DEAD  = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_period_tracker.sv
// Mirrors the pwm_generate period counter so ramp updates land exactly on
// period boundaries. Owns the fre_set shadow register (reloaded from
// period_set at every wrap) and the DIV_PERIODS update divider.
module pwm_period_tracker #(
  parameter int W           = 32,
  parameter int DIV_PERIODS = 1,
  parameter int PERIOD_RST  = 999
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] period_set,
  output logic         tick,
  output logic         upd,
  output logic [W-1:0] fre_set
);

  localparam int DW = (DIV_PERIODS > 1) ? $clog2(DIV_PERIODS) : 1;

  logic [W-1:0]  cnt;
  logic [DW-1:0] div_cnt;

  // Last count of the period; fre_set==0 makes every cycle a wrap.
  assign tick = (cnt == fre_set);
  assign upd  = tick && (div_cnt == DW'(DIV_PERIODS - 1));

  // Period counter, divider and period shadow register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      div_cnt <= '0;
      fre_set <= W'(PERIOD_RST);
    end else if (tick) begin
      cnt     <= '0;
      fre_set <= period_set;
      div_cnt <= upd ? '0 : div_cnt + 1'b1;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Soft-start / slew stage ahead of pwm_generate. Accepts duty+direction
// commands, slews wav_set toward the target by step_set at period boundaries
// and forces zero duty before any direction reversal.
// Optional macro PWM_RAMP_DEAD_EN: adds DEAD_PERIODS zero-duty updates before
// the direction flips on a reversal.
module pwm_duty_ramp
  import pwm_car_pkg::*;
#(
  parameter int W            = W_DEF,
  parameter int DIV_PERIODS  = 1,
  parameter int PERIOD_RST   = 999,
  parameter int DEAD_PERIODS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] period_set,
  input  logic [W-1:0] step_set,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_duty,
  input  logic         cmd_dir,
  output logic [W-1:0] fre_set,
  output logic [W-1:0] wav_set,
  output logic         dir_o,
  output logic         busy
);

  state_t        state_q, state_d;
  logic [W-1:0]  wav_d, tgt_q, tgt_d, tgt_c, acc_lim, acc_tgt, upd_lim;
  logic          dir_d, tgt_dir_q, tgt_dir_d, accept, tick, upd;
  logic [31:0]   dead_q, dead_d;
  logic [W:0]    step_x, up_x, dn_x;

  // 100% duty is fre_set+1; saturate so the limit still fits in W bits.
  function automatic logic [W-1:0] full_scale(input logic [W-1:0] per);
    return (&per) ? per : per + 1'b1;
  endfunction

  pwm_period_tracker #(
    .W          (W),
    .DIV_PERIODS(DIV_PERIODS),
    .PERIOD_RST (PERIOD_RST)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .period_set(period_set),
    .tick      (tick),
    .upd       (upd),
    .fre_set   (fre_set)
  );

  assign cmd_ready = (state_q == IDLE) || (state_q == RAMP);
  assign busy      = (state_q != IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Command target is limited by the running period; at an update the limit
  // is the period the new duty will actually be applied to.
  assign acc_lim = full_scale(fre_set);
  assign acc_tgt = (cmd_duty > acc_lim) ? acc_lim : cmd_duty;
  assign upd_lim = full_scale(tick ? period_set : fre_set);
  assign step_x  = (step_set == '0) ? (W+1)'(1) : {1'b0, step_set};

  // Next-state logic: command capture, then the FSM step on update edges.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    wav_d     = wav_set;
    dir_d     = dir_o;
    tgt_d     = tgt_q;
    tgt_dir_d = tgt_dir_q;
    dead_d    = dead_q;
    tgt_c     = '0;
    up_x      = '0;
    dn_x      = '0;

    if (accept) begin
      tgt_d     = acc_tgt;
      tgt_dir_d = cmd_dir;
      state_d   = (cmd_dir == dir_o || wav_set == '0) ? RAMP : DECEL;
    end

    if (upd) begin
      tgt_c = (tgt_d > upd_lim) ? upd_lim : tgt_d;
      tgt_d = tgt_c;
      up_x  = {1'b0, wav_set} + step_x;
      if (up_x > {1'b0, tgt_c}) up_x = {1'b0, tgt_c};
      dn_x  = ({1'b0, wav_set} > step_x) ? {1'b0, wav_set} - step_x : '0;

      case (state_d)
        RAMP: begin
          // At zero duty the bridge may be re-pointed without a reversal.
          if (wav_set == '0) dir_d = tgt_dir_d;
          if (wav_set < tgt_c)
            wav_d = up_x[W-1:0];
          else if (wav_set > tgt_c)
            wav_d = (dn_x < {1'b0, tgt_c}) ? tgt_c : dn_x[W-1:0];
          if (wav_d == tgt_c) state_d = IDLE;
        end
        DECEL: begin
          if (wav_set == '0) begin
`ifdef PWM_RAMP_DEAD_EN
            state_d = DEAD;
            dead_d  = '0;
`else
            dir_d   = tgt_dir_d;
            state_d = RAMP;
`endif
          end else begin
            wav_d = dn_x[W-1:0];
          end
        end
        DEAD: begin
          if (dead_q + 32'd1 >= 32'(DEAD_PERIODS)) begin
            dir_d   = tgt_dir_d;
            state_d = RAMP;
            dead_d  = '0;
          end else begin
            dead_d  = dead_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers; reset abandons any pending target at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wav_set   <= '0;
      dir_o     <= DIR_FWD;
      tgt_q     <= '0;
      tgt_dir_q <= DIR_FWD;
      dead_q    <= '0;
    end else begin
      state_q   <= state_d;
      wav_set   <= wav_d;
      dir_o     <= dir_d;
      tgt_q     <= tgt_d;
      tgt_dir_q <= tgt_dir_d;
      dead_q    <= dead_d;
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp with a behavioural pwm_generate stage
// downstream; watches that duty/period only change at period wraps.
module tb_pwm_duty_ramp;
  import pwm_car_pkg::*;

  localparam int W = 32;

  logic         clk, rst, cmd_valid, cmd_ready, cmd_dir, dir_o, busy;
  logic [W-1:0] period_set, step_set, cmd_duty, fre_set, wav_set;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wrap_cyc, last_wrap, glitch_cnt = 0, lows;
  logic [W-1:0] pre_fre;

  pwm_duty_ramp #(
    .W(W), .DIV_PERIODS(1), .PERIOD_RST(999), .DEAD_PERIODS(2)
  ) dut (
    .clk(clk), .rst(rst), .period_set(period_set), .step_set(step_set),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_duty(cmd_duty),
    .cmd_dir(cmd_dir), .fre_set(fre_set), .wav_set(wav_set),
    .dir_o(dir_o), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Downstream pwm_generate: counter 0..fre_set, output high while cnt<wav_set.
  logic [W-1:0] pcnt;
  logic         pwm_o;
  always @(posedge clk or posedge rst) begin
    if (rst) pcnt <= '0;
    else     pcnt <= (pcnt == fre_set) ? '0 : pcnt + 1'b1;
  end
  assign pwm_o = (pcnt < wav_set);

  // Glitch monitor: settings may only move across a wrap, PWM may only rise at count 0.
  logic [W-1:0] prev_wav, prev_fre;
  logic         prev_tick, prev_pwm, prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid) begin
        if ((wav_set != prev_wav || fre_set != prev_fre) && !prev_tick) glitch_cnt++;
        if (pwm_o && !prev_pwm && pcnt != '0) glitch_cnt++;
      end
      prev_wav   = wav_set;
      prev_fre   = fre_set;
      prev_tick  = (pcnt == fre_set);
      prev_pwm   = pwm_o;
      prev_valid = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Returns #1 after the next wrap edge; pre_fre holds fre_set just before it.
  task automatic wait_wrap();
    bit found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (pcnt == fre_set) begin
        pre_fre = fre_set;
        @(posedge clk);
        #1;
        found = 1'b1;
      end
    end
    if (!found) check("wrap_timeout", 0, 1);
    last_wrap = wrap_cyc;
    wrap_cyc  = cyc;
  endtask

  task automatic send_cmd(input logic [W-1:0] duty, input logic dir);
    cmd_duty  = duty;
    cmd_dir   = dir;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_duty = '0; cmd_dir = DIR_FWD;
    period_set = 32'd9; step_set = 32'd3;
    #23;
    check("rst_fre", fre_set, 999);
    check("rst_wav", wav_set, 0);
    check("rst_dir", dir_o, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    rst = 1'b0;

    wait_wrap();
    check("first_wrap_fre", fre_set, 9);

    // Ramp up 0 -> 7 forward.
    send_cmd(32'd7, DIR_FWD);
    check("ramp_busy", busy, 1);
    check("ramp_w0", wav_set, 0);
    wait_wrap(); check("ramp_w3", wav_set, 3);
    wait_wrap(); check("ramp_w6", wav_set, 6);
    check("ramp_period", wrap_cyc - last_wrap, 10);
    wait_wrap(); check("ramp_w7", wav_set, 7);
    check("ramp_period2", wrap_cyc - last_wrap, 10);
    check("ramp_idle", busy, 0);

    // Reversal 7/fwd -> 5/rev.
    send_cmd(32'd5, DIR_REV);
    check("rev_ready", cmd_ready, 0);
    wait_wrap(); check("rev_w4", wav_set, 4); check("rev_dir4", dir_o, 0);
    wait_wrap(); check("rev_w1", wav_set, 1);
    wait_wrap(); check("rev_w0", wav_set, 0); check("rev_dir0", dir_o, 0);
`ifdef PWM_RAMP_DEAD_EN
    for (int k = 0; k < 2; k++) begin
      wait_wrap(); check("dead_w0", wav_set, 0); check("dead_dir", dir_o, 0);
      check("dead_ready", cmd_ready, 0);
    end
`endif
    wait_wrap(); check("rev_flip_w", wav_set, 0); check("rev_flip_dir", dir_o, 1);
    check("rev_flip_ready", cmd_ready, 1);
    wait_wrap(); check("rev_w3", wav_set, 3);
    wait_wrap(); check("rev_w5", wav_set, 5); check("rev_idle", busy, 0);

    // Same duty, same direction: one RAMP update, no change.
    send_cmd(32'd5, DIR_REV);
    check("same_busy", busy, 1);
    wait_wrap(); check("same_w5", wav_set, 5); check("same_idle", busy, 0);

    // Clamp to 100%: 50 requested with period 9 settles at 10.
    send_cmd(32'd50, DIR_REV);
    wait_wrap(); check("clamp_w8", wav_set, 8);
    wait_wrap(); check("clamp_w10", wav_set, 10); check("clamp_idle", busy, 0);
    lows = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!pwm_o) lows++;
    end
    check("clamp_pwm_low_cycles", lows, 0);

    // Period change mid-ramp: 9 -> 19 taken at the next wrap only.
    wait_wrap();
    send_cmd(32'd0, DIR_REV);
    wait_wrap(); check("per_w7", wav_set, 7);
    period_set = 32'd19;
    @(negedge clk); check("per_hold", fre_set, 9);
    wait_wrap();
    check("per_pre", pre_fre, 9); check("per_new", fre_set, 19);
    check("per_w4", wav_set, 4);
    wait_wrap(); check("per_w1", wav_set, 1);
    check("per_len", wrap_cyc - last_wrap, 20);
    wait_wrap(); check("per_w0", wav_set, 0); check("per_idle", busy, 0);

    // Ramp, then start a reversal and reset in the middle of it.
    send_cmd(32'd15, DIR_REV);
    wait_wrap(); check("pre_rst_w3", wav_set, 3);
    wait_wrap(); check("pre_rst_w6", wav_set, 6);
    send_cmd(32'd6, DIR_FWD);
    check("pre_rst_ready", cmd_ready, 0);
    wait_wrap(); check("pre_rst_w3b", wav_set, 3); check("pre_rst_dir", dir_o, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_wav", wav_set, 0);
    check("arst_fre", fre_set, 999);
    check("arst_dir", dir_o, 0);
    check("arst_ready", cmd_ready, 1);
    check("arst_busy", busy, 0);
    @(negedge clk);
    #1 rst = 1'b0;

    check("no_glitch", glitch_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
